exp_lut_loader: RTL

Runtime writer for the dual-port exponent lookup RAM used by the FPU's exponent path. It accepts a valid/ready stream of table entries, packs them in pairs and writes both RAM ports in one cycle, so a full table of 2^ADDR_WIDTH entries loads in 2^(ADDR_WIDTH-1) write cycles. It then reads the table back through both ports and compares a modular checksum, replacing the file-based initialisation with a programmable and self-checked load.

---
 rtl/exp_lut_pkg.sv | 12 +
 rtl/exp_lut_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/exp_lut_pkg.sv
// Shared definitions for the exponent LUT loader and its dual-port RAM.
package exp_lut_pkg;
  localparam int EXP_LUT_ADDR_W = 4;
  localparam int EXP_LUT_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    CHECK  = 2'd3
  } lut_state_e;
endpackage

// File: rtl/exp_lut_loader.sv
// Streams table entries into the exponent LUT two per cycle, then reads the
// table back through both ports and compares a wrapping checksum.
module exp_lut_loader
  import exp_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = EXP_LUT_ADDR_W,
  parameter int DATA_WIDTH = EXP_LUT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);
  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = '1;
  localparam logic [ADDR_WIDTH-1:0] RD_END    = {1'b1, {PW{1'b0}}};

  lut_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         pair_q, pair_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] rdsum_q, rdsum_d;
  logic [DATA_WIDTH-1:0] rd_acc;
  logic                  we_q, we_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  // [0]: read address on the bus this cycle, [1]: RAM data for it is valid
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic                  accept;

  assign accept = in_valid && rdy_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pair_d     = pair_q;
    hold_d     = hold_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    csum_d     = csum_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    err_d      = err_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};

    rd_acc = rdsum_q;
    if (vld_pipe_q[1]) rd_acc = rdsum_q + ram_q_a + ram_q_b;
    rdsum_d = rd_acc;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          rdy_d    = 1'b1;
          busy_d   = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          csum_d   = '0;
          rdsum_d  = '0;
          err_d    = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          csum_d   = csum_q + in_data;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (!wr_ptr_q[0]) begin
            hold_d = in_data;
          end else begin
            // Odd beat completes a pair: both ports written next cycle.
            data_a_d = hold_q;
            data_b_d = in_data;
            pair_d   = wr_ptr_q[ADDR_WIDTH-1:1];
            we_d     = 1'b1;
          end
          if (wr_ptr_q == LAST_BEAT) begin
            state_d = VERIFY;
            rdy_d   = 1'b0;
          end
        end
      end
      VERIFY: begin
        // First VERIFY cycle still carries the final write pulse; reads
        // are issued from the following cycle on.
        if (rd_ptr_q == RD_END) begin
          state_d  = CHECK;
          rd_ptr_d = '0;
          pair_d   = '0;
        end else begin
          pair_d        = rd_ptr_q[PW-1:0];
          rd_ptr_d      = rd_ptr_q + 1'b1;
          vld_pipe_d[0] = 1'b1;
        end
      end
      CHECK: begin
        err_d   = (rd_acc != csum_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pair_q     <= '0;
      hold_q     <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      csum_q     <= '0;
      rdsum_q    <= '0;
      we_q       <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pair_q     <= pair_d;
      hold_q     <= hold_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      csum_q     <= csum_d;
      rdsum_q    <= rdsum_d;
      we_q       <= we_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign in_ready   = rdy_q;
  assign ram_addr_a = {pair_q, 1'b0};
  assign ram_addr_b = {pair_q, 1'b1};
  assign ram_data_a = data_a_q;
  assign ram_data_b = data_b_q;
  assign ram_we_a   = we_q;
  assign ram_we_b   = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign checksum   = csum_q;
endmodule
